// File: rtl/mmio_timer_responder_if.sv
// Data-memory request/response bundle for the machine-timer responder.
// The core side drives the request; the device returns resp/dException.
interface mmio_timer_responder_if;
   logic        enable;
   logic [1:0]  memo;
   logic [7:0]  mask;
   logic [63:0] addr;
   logic [63:0] data;
   logic [63:0] resp;
   logic        dException;

   modport master (
      output enable, memo, mask, addr, data,
      input  resp, dException
   );

   modport slave (
      input  enable, memo, mask, addr, data,
      output resp, dException
   );
endinterface

// File: rtl/mmio_timer_responder.sv
// Machine timer / software interrupt device: msip, mtimecmp, mtime.
// MMIO_TIMER_RTC_TICK_EN: tick from synchronized rtc_tick, not the prescaler.
module mmio_timer_responder #(
   parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
   parameter int unsigned TICK_DIV  = 16
) (
   input  logic CLK,
   input  logic RESET,
`ifdef MMIO_TIMER_RTC_TICK_EN
   input  logic rtc_tick,
`endif
   mmio_timer_responder_if.slave bus,
   output logic timer_irq,
   output logic soft_irq
);

   logic [63:0] mtime;
   logic [63:0] mtimecmp;
   logic        msip;

   logic        hit;
   logic        aligned;
   logic        sel_msip;
   logic        sel_cmp;
   logic        sel_time;
   logic        ok;
   logic        wr;
   logic        tick;
   logic [63:0] rdata;
   logic [63:0] wmask;
   logic [63:0] cmp_wr;
   logic [63:0] time_wr;

   // Window is 64 KiB aligned, so the high bits fully decide a hit.
   always_comb begin
      hit      = bus.addr[63:16] == BASE_ADDR[63:16];
      aligned  = bus.addr[2:0] == 3'b000;
      sel_msip = bus.addr[15:3] == 13'h0000;
      sel_cmp  = bus.addr[15:3] == 13'h0800;
      sel_time = bus.addr[15:3] == 13'h17ff;
      ok       = bus.enable & hit & aligned
               & (sel_msip | sel_cmp | sel_time)
               & ~bus.memo[1];
      wr       = ok & bus.memo[0];
      rdata    = '0;
      unique case (1'b1)
         sel_msip: rdata = {63'd0, msip};
         sel_cmp:  rdata = mtimecmp;
         sel_time: rdata = mtime;
         default:  rdata = '0;
      endcase
      bus.resp       = (ok & ~bus.memo[0]) ? rdata : '0;
      bus.dException = bus.enable & ~ok;
   end

   always_comb begin
      wmask = '0;
      for (int i = 0; i < 8; i++)
         wmask[8*i +: 8] = {8{bus.mask[i]}};
      cmp_wr  = (mtimecmp & ~wmask) | (bus.data & wmask);
      time_wr = (mtime & ~wmask) | (bus.data & wmask);
   end

`ifdef MMIO_TIMER_RTC_TICK_EN
   logic [2:0] sync;
   logic [1:0] vld;
   logic       armed;

   // armed needs a low level seen after reset, so a held rise is ignored.
   assign tick = sync[1] & ~sync[2] & armed;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         sync  <= '0;
         vld   <= '0;
         armed <= 1'b0;
      end else begin
         sync  <= {sync[1:0], rtc_tick};
         vld   <= {vld[0], 1'b1};
         armed <= armed | (vld[1] & ~sync[1]);
      end
   end
`else
   localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

   logic [15:0] pcnt;

   assign tick = pcnt == DIV_LAST;

   always_ff @(posedge CLK) begin
      if (!RESET)
         pcnt <= '0;
      else if (tick)
         pcnt <= '0;
      else
         pcnt <= pcnt + 16'd1;
   end
`endif

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         msip      <= 1'b0;
         timer_irq <= 1'b0;
         soft_irq  <= 1'b0;
      end else begin
         if (wr & sel_msip & bus.mask[0])
            msip <= bus.data[0];
         if (wr & sel_cmp)
            mtimecmp <= cmp_wr;
         // A store to mtime swallows a coincident tick.
         if (wr & sel_time)
            mtime <= time_wr;
         else if (tick)
            mtime <= mtime + 64'd1;
         timer_irq <= mtime >= mtimecmp;
         soft_irq  <= msip;
      end
   end

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Randomized bench for mmio_timer_responder against a cycle-count model.
// Define MMIO_TIMER_RTC_TICK_EN for both files to test the RTC tick path.
module tb_mmio_timer_responder;

   localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
   localparam int DIV = 16;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   logic timer_irq;
   logic soft_irq;
`ifdef MMIO_TIMER_RTC_TICK_EN
   logic rtc_tick = 1'b0;
`endif

   mmio_timer_responder_if bus();

   mmio_timer_responder #(
      .BASE_ADDR(BASE),
      .TICK_DIV (DIV)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
`ifdef MMIO_TIMER_RTC_TICK_EN
      .rtc_tick (rtc_tick),
`endif
      .bus      (bus),
      .timer_irq(timer_irq),
      .soft_irq (soft_irq)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_on = 1'b1;

   logic [63:0] m_time;
   logic [63:0] m_cmp;
   bit          m_msip;
   bit          m_tirq;
   bit          m_sirq;
   longint      cyc;

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] d,
                                         logic [7:0] m);
      for (int i = 0; i < 8; i++)
         if (m[i]) o[8*i +: 8] = d[8*i +: 8];
      return o;
   endfunction

   // Register index by offset: 0 msip, 1 mtimecmp, 2 mtime, -1 none.
   task automatic model_access(input bit en, input logic [1:0] mo,
                               input logic [63:0] ad, output bit flt,
                               output logic [63:0] rd, output int idx);
      logic [63:0] off;
      bit in_win;
      off = ad - BASE;
      in_win = (ad >= BASE) && (off <= 64'hFFFF);
      idx = -1;
      if (in_win) begin
         case (off)
            64'h0000: idx = 0;
            64'h4000: idx = 1;
            64'hBFF8: idx = 2;
            default:  idx = -1;
         endcase
      end
      flt = en && (!in_win || (ad % 8) != 0 || idx < 0 || mo > 2'd1);
      rd = '0;
      if (en && !flt && mo == 2'd0)
         rd = (idx == 0) ? {63'd0, m_msip} :
              (idx == 1) ? m_cmp : m_time;
   endtask

   task automatic model_reset();
      m_time = '0;
      m_cmp  = ONES;
      m_msip = 1'b0;
      m_tirq = 1'b0;
      m_sirq = 1'b0;
      cyc    = 0;
   endtask

   task automatic step(input bit en, input logic [1:0] mo,
                       input logic [7:0] mk, input logic [63:0] ad,
                       input logic [63:0] dt, output logic [63:0] got,
                       output logic dex);
      bit flt;
      bit tk;
      bit nt;
      bit ns;
      logic [63:0] rd;
      int idx;
      bus.enable = en;
      bus.memo   = mo;
      bus.mask   = mk;
      bus.addr   = ad;
      bus.data   = dt;
      #1;
      model_access(en, mo, ad, flt, rd, idx);
      got = bus.resp;
      dex = bus.dException;
      if (chk_on) begin
         check("resp", bus.resp, rd);
         check("dexc", {63'd0, bus.dException}, {63'd0, flt});
         check("tirq", {63'd0, timer_irq}, {63'd0, m_tirq});
         check("sirq", {63'd0, soft_irq}, {63'd0, m_sirq});
      end
      @(posedge CLK);
      if (!RESET) begin
         model_reset();
      end else begin
`ifdef MMIO_TIMER_RTC_TICK_EN
         tk = 1'b0;
`else
         tk = (cyc % DIV) == DIV - 1;
`endif
         nt = m_time >= m_cmp;
         ns = m_msip;
         if (en && !flt && mo == 2'd1 && idx == 2)
            m_time = merge(m_time, dt, mk);
         else if (tk)
            m_time = m_time + 64'd1;
         if (en && !flt && mo == 2'd1 && idx == 1)
            m_cmp = merge(m_cmp, dt, mk);
         if (en && !flt && mo == 2'd1 && idx == 0 && mk[0])
            m_msip = dt[0];
         m_tirq = nt;
         m_sirq = ns;
         cyc++;
      end
      #1;
   endtask

   task automatic idle(int n);
      logic [63:0] g;
      logic d;
      for (int i = 0; i < n; i++)
         step(1'b0, 2'd0, 8'h00, BASE + 64'hBFF8, '0, g, d);
   endtask

   task automatic ld(logic [63:0] off, output logic [63:0] got);
      logic d;
      step(1'b1, 2'd0, 8'h00, BASE + off, '0, got, d);
   endtask

   task automatic st(logic [63:0] off, logic [7:0] mk, logic [63:0] dt);
      logic [63:0] g;
      logic d;
      step(1'b1, 2'd1, mk, BASE + off, dt, g, d);
   endtask

   task automatic do_reset();
      RESET = 1'b0;
      idle(3);
      RESET = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] got;
      logic dex;
      logic [63:0] addr_tbl[8];
      bit t_now;
      int a;
      int b;

      bus.enable = 1'b0;
      bus.memo   = 2'd0;
      bus.mask   = 8'h00;
      bus.addr   = '0;
      bus.data   = '0;
      #1;
      repeat (3) @(posedge CLK);
      model_reset();
      #1;
      RESET = 1'b1;

      ld(64'hBFF8, got);
      check("rst_mtime", got, 64'd0);
      ld(64'h4000, got);
      check("rst_mtimecmp", got, ONES);
      check("rst_tirq", {63'd0, timer_irq}, 64'd0);
      check("rst_sirq", {63'd0, soft_irq}, 64'd0);

`ifndef MMIO_TIMER_RTC_TICK_EN
      idle(158);
      ld(64'hBFF8, got);
      check("mtime_160cyc", got, 64'd10);
`endif

      st(64'h4000, 8'h0F, 64'h1122_3344_5566_7788);
      ld(64'h4000, got);
      check("masked_cmp", got, 64'hFFFF_FFFF_5566_7788);
      st(64'h0000, 8'h01, 64'd1);
      check("sirq_commit", {63'd0, soft_irq}, 64'd0);
      idle(1);
      check("sirq_set", {63'd0, soft_irq}, 64'd1);
      st(64'h0000, 8'h01, 64'd0);
      idle(1);
      check("sirq_clr", {63'd0, soft_irq}, 64'd0);

`ifndef MMIO_TIMER_RTC_TICK_EN
      do_reset();
      st(64'h4000, 8'hFF, 64'd5);
      a = -1;
      b = -1;
      for (int i = 0; i < 200; i++) begin
         t_now = timer_irq;
         ld(64'hBFF8, got);
         if (got == 64'd5 && a < 0) a = i;
         if (t_now && b < 0) b = i;
      end
      check("irq_lag", 64'(b - a), 64'd1);
      st(64'h4000, 8'hFF, 64'd100);
      check("tirq_pre", {63'd0, timer_irq}, 64'd1);
      idle(1);
      check("tirq_fall", {63'd0, timer_irq}, 64'd0);

      do_reset();
      for (int i = 0; i < 2 * DIV && (cyc % DIV) != DIV - 1; i++)
         idle(1);
      st(64'hBFF8, 8'hFF, ONES);
      ld(64'hBFF8, got);
      check("collision", got, ONES);
      check("coll_tirq", {63'd0, timer_irq}, 64'd1);
      idle(DIV - 1);
      ld(64'hBFF8, got);
      check("wrap", got, 64'd0);
      check("wrap_tirq", {63'd0, timer_irq}, 64'd0);
`endif

      st(64'h4000, 8'hFF, 64'h0000_0000_0000_0040);
      step(1'b1, 2'd1, 8'hFF, BASE + 64'h4004, ONES, got, dex);
      check("misalign", {63'd0, dex}, 64'd1);
      step(1'b1, 2'd0, 8'hFF, BASE + 64'h0008, ONES, got, dex);
      check("unmapped", {63'd0, dex}, 64'd1);
      step(1'b1, 2'd1, 8'hFF, BASE + 64'h10000, ONES, got, dex);
      check("outside", {63'd0, dex}, 64'd1);
      step(1'b1, 2'd2, 8'hFF, BASE + 64'h4000, ONES, got, dex);
      check("reserved", {63'd0, dex}, 64'd1);
      check("reserved_resp", got, 64'd0);
      ld(64'h4000, got);
      check("cmp_kept", got, 64'h40);
      step(1'b0, 2'd0, 8'h00, BASE + 64'hBFF8, '0, got, dex);
      check("idle_resp", got, 64'd0);

      addr_tbl[0] = BASE;
      addr_tbl[1] = BASE + 64'h4000;
      addr_tbl[2] = BASE + 64'hBFF8;
      addr_tbl[3] = BASE + 64'h4004;
      addr_tbl[4] = BASE + 64'h0008;
      addr_tbl[5] = BASE + 64'h10000;
      addr_tbl[6] = BASE - 64'd8;
      addr_tbl[7] = BASE + 64'hBFFC;
      for (int i = 0; i < 400; i++) begin
         logic [63:0] rd;
         rd = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rd = rd >> $urandom_range(0, 63);
         RESET = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
         step($urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)),
              8'($urandom), addr_tbl[$urandom_range(0, 7)], rd, got, dex);
      end
      RESET = 1'b1;

`ifdef MMIO_TIMER_RTC_TICK_EN
      chk_on = 1'b0;
      do_reset();
      idle(4);
      for (int p = 0; p < 4; p++) begin
         rtc_tick = 1'b1;
         idle(5);
         rtc_tick = 1'b0;
         idle(5);
      end
      idle(4);
      ld(64'hBFF8, got);
      check("rtc_four", got, 64'd4);
      RESET = 1'b0;
      rtc_tick = 1'b1;
      idle(3);
      RESET = 1'b1;
      idle(10);
      rtc_tick = 1'b0;
      idle(6);
      ld(64'hBFF8, got);
      check("rtc_held", got, 64'd0);
      rtc_tick = 1'b1;
      idle(5);
      rtc_tick = 1'b0;
      idle(5);
      ld(64'hBFF8, got);
      check("rtc_after", got, 64'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
Memory-mapped machine-timer/software-interrupt device. It is the responder end of the core's memAction data-memory interface: it takes the same request fields and returns a response. It decodes a 64 KiB window and owns msip, mtimecmp and a free-running mtime counter. It raises timer and software interrupt lines toward the core, sitting beside the RAM on the data path.

Parameters:
BASE_ADDR, 64'h0000_0000_0200_0000, window base; must be 64 KiB aligned.
TICK_DIV, 16, CLK cycles per mtime increment; legal range 1..65535.

Ports:
CLK  input  1  clock.
RESET  input  1  synchronous, active-low reset.
enable  input  1  request valid this cycle (memAction _enable).
memo  input  2  op: 2'b00 load, 2'b01 store, 2'b10/2'b11 reserved.
mask  input  8  byte-enable for stores; bit i covers data[8i+7:8i].
addr  input  64  byte address.
data  input  64  store data.
resp  output  64  load data (memAction _return), combinational.
dException  output  1  access fault, combinational.
timer_irq  output  1  registered, mtime >= mtimecmp.
soft_irq  output  1  registered, msip[0].

Behaviour:
- Register map (offset = addr - BASE_ADDR): 0x0000 msip (bit0 only, bits 63:1 read 0); 0x4000 mtimecmp; 0xBFF8 mtime. All are 64-bit and 8-byte aligned.
- Hit: addr within [BASE_ADDR, BASE_ADDR+0xFFFF]; the window compare is done on all 64 address bits.
- dException=1 when enable, and any of the following holds:
  - the address misses the window;
  - addr[2:0]!=0;
  - the offset is unmapped;
  - memo is reserved.
- When dException is set: resp=0 and no state change.
- dException=0 and resp=0 whenever enable=0.
- Load: resp equals the current register value in the same cycle, with zero latency. Loads have no side effects.
- Store: committed at the next CLK edge. For each byte i with mask[i]=1, reg byte i <= data byte i. Unmasked bytes are unchanged. mask=0 is a legal no-op.
- Prescaler: 16-bit counter pcnt, 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and asserts tick for that cycle.
- mtime: increments by 1 on tick. It wraps from 2^64-1 to 0 with no flag.
- Simultaneous mtime store and tick: the store wins. Written bytes take data; unwritten bytes keep the old value; the increment is dropped. pcnt still wraps normally.
- A store to mtime does not reset pcnt.
- timer_irq <= (mtime >= mtimecmp), unsigned, evaluated on pre-edge register values. Result: one cycle of lag after any mtime or mtimecmp change.
- soft_irq <= msip[0] (pre-edge value). It is asserted the cycle after the edge that commits the store.
- Reset (RESET=0 at a CLK edge), overriding any concurrent request or tick:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, pcnt=0;
  - timer_irq=0, soft_irq=0.
  - While in reset, resp/dException still decode combinationally but stores are discarded.
- There is no backpressure: every enabled request completes in its cycle.

Optional Feature:
MMIO_TIMER_RTC_TICK_EN
- Defined:
  - Adds port rtc_tick (input, 1), an asynchronous real-time-clock signal.
  - It passes through a 2-flop synchronizer plus an edge register. Tick is the synchronized rising edge, with 3-cycle latency from an input rise.
  - The prescaler and TICK_DIV are unused. Sync flops reset to 0.
  - A rise held through reset is not counted after release unless it toggles again.
- Undefined: no rtc_tick port; the prescaler generates tick.

Test Plan:
1. Reset sequence: hold RESET=0 for 3 cycles, then release. Check:
   - load 0xBFF8 -> resp=0;
   - load 0x4000 -> resp=64'hFFFF_FFFF_FFFF_FFFF;
   - timer_irq=0, soft_irq=0.
   Then with TICK_DIV=16, wait 160 cycles -> mtime reads 10.
2. Masked store: store data=64'h1122_3344_5566_7788 with mask=8'h0F to mtimecmp (preset 64'hFFFF_FFFF_FFFF_FFFF) -> reads 64'hFFFF_FFFF_5566_7788.
   Then store msip data=1, mask=8'h01 -> soft_irq=1 one cycle later.
   Then store data=0 -> soft_irq=0.
3. Compare: set mtimecmp=5 and run from reset -> timer_irq rises exactly one cycle after mtime becomes 5.
   Then store mtimecmp=100 -> timer_irq falls one cycle after commit.
4. Collision: time a full-mask mtime store of 64'hFFFF_FFFF_FFFF_FFFF to the tick cycle -> reads 64'hFFFF_FFFF_FFFF_FFFF, not incremented.
   The next tick wraps mtime to 0, and timer_irq clears if mtimecmp=64'hFFFF_FFFF_FFFF_FFFF.
5. Faults, each returning dException=1 with resp=0 and no register change:
   - addr=BASE+0x4004 (misaligned);
   - addr=BASE+0x0008 (unmapped);
   - addr=BASE+0x10000 (outside window);
   - memo=2'b10 (reserved).
   Separately, enable=0 with addr=BASE+0xBFF8 -> resp=0.
6. With MMIO_TIMER_RTC_TICK_EN defined:
   - 4 rtc_tick pulses, each 5 cycles high and 5 low -> mtime=4;
   - a pulse raised while RESET=0 and held through release -> not counted.
